// File: rtl/alu_issue_sequencer.sv
// alu_issue_sequencer
//
// Feeds the 8-bit VS-ALU from a small instruction FIFO. Each packed word
// {opcode[3:0], A[7:0], B[7:0]} is launched on alu_*, held for ALU_LAT
// rising edges, and then the ALU result is captured. The result and its
// opcode are offered on an output valid/ready handshake. Only one
// instruction is in flight at a time.
//
// Parameters
//   DEPTH   : instruction FIFO entries (power of two, 2..16)
//   ALU_LAT : rising edges from launch on alu_* to sampling alu_res (>= 1)
//
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid/in_ready        : instruction handshake, in_instr = {op, A, B}
//   alu_opcode/alu_a/alu_b   : operands to the ALU, change only on issue
//   alu_res                  : ALU result, sampled ALU_LAT edges after issue
//   out_valid/out_ready      : result handshake, out_result/out_opcode
//   busy                     : FIFO non-empty or an instruction in flight
//   issue_count              : instructions issued, modulo 256
module alu_issue_sequencer #(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [19:0] in_instr,
    output logic [3:0]  alu_opcode,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    input  logic [7:0]  alu_res,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_result,
    output logic [3:0]  out_opcode,
    output logic        busy,
    output logic [7:0]  issue_count
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int OCC_W  = $clog2(DEPTH + 1);
    localparam int WAIT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    localparam logic [OCC_W-1:0]  OCC_FULL  = OCC_W'(DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ALU_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [19:0]        mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [OCC_W-1:0]   occ;
    logic [WAIT_W-1:0]  wait_cnt;

    logic               empty;
    logic               push;
    logic               pop;
    logic               capture;
    logic               release_res;
    logic [19:0]        head;

    // Readiness comes only from registered occupancy, so a pop in the same
    // cycle never opens a slot for a push while the FIFO is full.
    assign empty    = (occ == '0);
    assign in_ready = (occ != OCC_FULL);
    assign push     = in_valid && in_ready;
    assign head     = mem[rd_ptr];
    assign busy     = (state != S_IDLE) || !empty;

    always_comb begin
        state_nxt   = state;
        pop         = 1'b0;
        capture     = 1'b0;
        release_res = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // wait_cnt counts edges since issue minus one, so this is
                // the ALU_LAT-th edge after the operands were launched.
                if (wait_cnt == WAIT_LAST) begin
                    capture   = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    release_res = 1'b1;
                    if (!empty) begin
                        // Back-to-back issue on the handshake edge keeps the
                        // ALU busy one result per ALU_LAT+1 cycles.
                        pop       = 1'b1;
                        state_nxt = S_WAIT;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FIFO storage: data only, stale entries are unreachable after reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occ         <= '0;
            wait_cnt    <= '0;
            issue_count <= '0;
            alu_opcode  <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_opcode  <= '0;
        end else begin
            state <= state_nxt;

            // Pointers wrap naturally because DEPTH is a power of two.
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase

            // Issue stage: launch operands onto the ALU
            if (pop) begin
                alu_opcode  <= head[19:16];
                alu_a       <= head[15:8];
                alu_b       <= head[7:0];
                issue_count <= issue_count + 8'd1;
                wait_cnt    <= '0;
            end else if (state == S_WAIT && !capture) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end

            // Capture stage: result held stable until the consumer takes it
            if (capture) begin
                out_result <= alu_res;
                out_opcode <= alu_opcode;
                out_valid  <= 1'b1;
            end else if (release_res) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// tb_alu_issue_sequencer
//
// Directed bench for alu_issue_sequencer (DEPTH=4, ALU_LAT=2). A small
// combinational ALU model answers the DUT's operands:
//   res = (A + B) ^ {op, op}   (plain A+B for opcode 0)
module tb_alu_issue_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [19:0] in_instr = '0;
    logic [3:0]  alu_opcode;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [7:0]  alu_res;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_result;
    logic [3:0]  out_opcode;
    logic        busy;
    logic [7:0]  issue_count;

    int total = 0;
    int bad   = 0;

    logic [11:0] q[$];

    always #5 clk = ~clk;

    alu_issue_sequencer #(
        .DEPTH   (4),
        .ALU_LAT (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .alu_opcode  (alu_opcode),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_res     (alu_res),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_opcode  (out_opcode),
        .busy        (busy),
        .issue_count (issue_count)
    );

    function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
        logic [7:0] s;
        s = a + b;
        return s ^ {op, op};
    endfunction

    assign alu_res = alu_fn(alu_opcode, alu_a, alu_b);

    function automatic logic [11:0] expect_of(input logic [19:0] w);
        return {w[19:16], alu_fn(w[19:16], w[15:8], w[7:0])};
    endfunction

    function automatic logic [19:0] w_ord(input int i);
        return {4'(i + 1), 8'(8'h10 + i), 8'(8'h20 + i)};
    endfunction

    function automatic logic [19:0] w_pp(input int i);
        return {4'(8 + i), 8'(8'h40 + i), 8'(8'h50 + i)};
    endfunction

    function automatic logic [19:0] w_rst(input int i);
        return {4'(3 + i), 8'(8'hA0 + i), 8'(8'hB0 + i)};
    endfunction

    function automatic logic [19:0] w_str(input int i);
        return {4'(i), 8'(i * 7), 8'(i * 3 + 1)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [19:0] w);
        chk("push_rdy", in_ready, 1);
        in_valid = 1'b1;
        in_instr = w;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        out_ready = 1'b1;
        while (n < 200) begin
            if (out_valid) begin
                if (q.size() == 0) chk({tag, "_extra"}, 1, 0);
                else chk(tag, {out_opcode, out_result}, q.pop_front());
            end
            if (q.size() == 0 && !busy) break;
            tick();
            n++;
        end
        chk({tag, "_left"}, q.size(), 0);
    endtask

    initial begin
        int   idx;
        int   ridx;
        int   n;
        logic acc;
        logic saw;

        // ---------------- reset state ----------------
        rst = 1'b1;
        tick();
        tick();
        chk("rst_vld", out_valid, 0);
        chk("rst_alu", {alu_opcode, alu_a, alu_b}, 0);
        chk("rst_out", {out_opcode, out_result}, 0);
        chk("rst_cnt", issue_count, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        tick();
        chk("rst_rdy", in_ready, 1);

        // ---------------- single instruction, A+B ----------------
        out_ready = 1'b1;
        push({4'h0, 8'h05, 8'h03});
        chk("t1_nobypass", {alu_opcode, alu_a, alu_b}, 0);
        chk("t1_busy_q", busy, 1);
        tick();
        chk("t1_alu", {alu_opcode, alu_a, alu_b}, 20'h00503);
        chk("t1_cnt", issue_count, 1);
        chk("t1_vld0", out_valid, 0);
        tick();
        chk("t1_vld1", out_valid, 0);
        tick();
        chk("t1_vld2", out_valid, 1);
        chk("t1_res", {out_opcode, out_result}, 12'h008);
        chk("t1_busy_d", busy, 1);
        tick();
        chk("t1_vld3", out_valid, 0);
        chk("t1_busy_end", busy, 0);

        // ---------------- fill to full, backpressure, ordering ----------------
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(w_ord(i));
        chk("full_rdy", in_ready, 0);
        chk("full_busy", busy, 1);
        in_valid = 1'b1;
        in_instr = w_ord(5);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_vld", out_valid, 1);
            chk("bp_res", {out_opcode, out_result}, expect_of(w_ord(0)));
            chk("bp_alu", {alu_opcode, alu_a, alu_b}, w_ord(0));
            chk("bp_rdy", in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        chk("hs_alu", {alu_opcode, alu_a, alu_b}, w_ord(1));
        chk("hs_vld", out_valid, 0);
        chk("hs_cnt", issue_count, 3);
        chk("hs_rdy", in_ready, 1);
        tick();
        in_valid = 1'b0;
        for (int i = 1; i < 6; i++) q.push_back(expect_of(w_ord(i)));
        drain("ord");
        chk("ord_cnt", issue_count, 7);

        // ---------------- simultaneous push and pop at 2 entries ----------------
        out_ready = 1'b0;
        push(w_pp(0));
        push(w_pp(1));
        push(w_pp(2));
        tick();
        chk("pp_vld", out_valid, 1);
        chk("pp_res0", {out_opcode, out_result}, expect_of(w_pp(0)));
        out_ready = 1'b1;
        push(w_pp(3));
        chk("pp_rdy", in_ready, 1);
        chk("pp_alu", {alu_opcode, alu_a, alu_b}, w_pp(1));
        chk("pp_vld0", out_valid, 0);
        out_ready = 1'b0;
        push(w_pp(4));
        chk("pp_rdy3", in_ready, 1);
        push(w_pp(5));
        chk("pp_rdy4", in_ready, 0);
        for (int i = 1; i < 6; i++) q.push_back(expect_of(w_pp(i)));
        drain("pp");
        chk("pp_cnt", issue_count, 13);

        // ---------------- reset mid-operation ----------------
        out_ready = 1'b0;
        push(w_rst(0));
        tick();
        tick();
        tick();
        chk("mr_vld", out_valid, 1);
        for (int i = 1; i < 5; i++) push(w_rst(i));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("mr_alu", {alu_opcode, alu_a, alu_b}, w_rst(1));
        chk("mr_cnt", issue_count, 15);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_vld0", out_valid, 0);
        chk("mr_busy", busy, 0);
        chk("mr_cnt0", issue_count, 0);
        chk("mr_rdy", in_ready, 1);
        chk("mr_alu0", {alu_opcode, alu_a, alu_b}, 0);
        out_ready = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid || busy) saw = 1'b1;
        end
        chk("mr_noresult", saw, 0);

        // ---------------- 257-instruction stream, opcode wrap ----------------
        idx  = 0;
        ridx = 0;
        n    = 0;
        out_ready = 1'b1;
        while (ridx < 257 && n < 2000) begin
            in_valid = (idx < 257);
            in_instr = w_str(idx);
            acc = in_valid && in_ready;
            tick();
            n++;
            if (acc) idx++;
            if (out_valid) begin
                chk("strm", {out_opcode, out_result}, expect_of(w_str(ridx)));
                ridx++;
            end
        end
        in_valid = 1'b0;
        chk("strm_n", ridx, 257);
        chk("strm_cycles", n, 772);
        tick();
        chk("strm_cnt", issue_count, 1);
        chk("strm_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_sequencer.md
Name: alu_issue_sequencer

Overview:
- Upstream feeder for the 8-bit VS-ALU.
- Accepts packed instruction words over a valid/ready handshake and buffers them in a small FIFO.
- Issues one instruction at a time: drives the ALU's opcode/A/B, waits a fixed ALU latency, then captures the ALU result.
- Presents each result with its opcode over a second valid/ready handshake, so the ALU runs without software-level timing.

Parameters:
- DEPTH, 4: instruction FIFO entries; power of two, 2..16.
- ALU_LAT, 2: rising edges from operands launched on alu_* until alu_res is sampled.

Ports:
- clk, in, 1: system clock, all logic on rising edge.
- rst, in, 1: synchronous active-high reset.
- in_valid, in, 1: in_instr valid.
- in_ready, out, 1: FIFO can accept a word.
- in_instr, in, 20: [19:16] opcode, [15:8] A, [7:0] B.
- alu_opcode, out, 4: opcode to ALU.
- alu_a, out, 8: operand A to ALU.
- alu_b, out, 8: operand B to ALU.
- alu_res, in, 8: ALU result.
- out_valid, out, 1: out_result/out_opcode valid.
- out_ready, in, 1: consumer accepts result.
- out_result, out, 8: captured ALU result.
- out_opcode, out, 4: opcode of that result.
- busy, out, 1: FIFO non-empty or FSM not IDLE.
- issue_count, out, 8: number of instructions issued, modulo 256.

Behaviour:
- Reset (rst=1 at a clk edge):
  - FIFO emptied, pointers 0, FSM to IDLE, counter cleared.
  - All registered outputs 0: alu_opcode, alu_a, alu_b, out_valid, out_result, out_opcode, issue_count.
  - in_ready becomes 1 on the first edge after rst deasserts.
  - Reset mid-operation discards the FIFO contents, the in-flight instruction and any pending result; no partial output.
- FIFO:
  - in_ready = !full, derived from registered occupancy.
  - Push on edge when in_valid && in_ready.
  - When full, in_ready=0 even if a pop occurs that cycle; the push is refused and the producer holds its word.
  - Simultaneous push and pop when not full: occupancy unchanged, both take effect.
  - Pointers wrap modulo DEPTH.
  - Order is strictly FIFO.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - If FIFO non-empty: pop head, register its fields onto alu_opcode/alu_a/alu_b, increment issue_count, clear wait counter, go WAIT.
  - An instruction pushed at edge E is issued at edge E+1 at the earliest, with no bypass.
- WAIT:
  - Counter increments each edge.
  - At the ALU_LAT-th edge after issue: sample alu_res into out_result, copy alu_opcode into out_opcode, set out_valid=1, go DONE.
- DONE:
  - out_valid=1 is held; out_result/out_opcode stay stable until the handshake.
  - On edge with out_ready=1: if FIFO non-empty, issue the next instruction in the same edge as IDLE would, clear out_valid, go WAIT; else clear out_valid, go IDLE.
- Timing and holds:
  - alu_* hold the last issued instruction through WAIT, DONE and IDLE; they change only on issue.
  - Throughput with out_ready held high: one result per ALU_LAT+1 cycles.
- issue_count wraps 255 -> 0.
- busy is combinational: (state != IDLE) || !empty.
- The block does not interpret opcode values; all 16 codes pass through unchanged.

Test Plan:
- Reset, push {0000,0x05,0x03} with ALU model = A+B, ALU_LAT=2, out_ready=1 -> alu_* = 0,05,03 one edge after push; out_valid rises 2 edges later with out_result=0x08, out_opcode=0; issue_count=1; busy falls after handshake.
- Hold out_ready=0, push 6 words back-to-back -> in_ready drops once 4 are buffered plus 1 in flight; 6th word held by producer; no word lost or duplicated; results emerge in push order once out_ready=1.
- Backpressure: out_valid high, out_ready=0 for 10 cycles -> out_result, out_opcode and alu_* unchanged each cycle; next issue occurs exactly on the handshake edge.
- Assert rst for 1 cycle during WAIT with 3 words buffered -> next cycle out_valid=0, busy=0, issue_count=0, in_ready=1; no result ever appears for the discarded words.
- Stream 257 instructions with out_ready=1 -> issue_count reads 0x01 after the last issue; results match model for opcodes 0000..1111 cycled.
- Simultaneous push and pop with FIFO at 2 entries -> occupancy stays 2; in_ready stays 1; ordering preserved.
